// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg
// Shared types and encodings for the multi-cycle RV32I sequencing controller:
//   - state_t       : controller state (IF/ID/EX/MEM/WB/HALT)
//   - inst_class_t  : instruction class produced by the opcode decoder
//   - opcode values recognised by the decoder
//   - pc_source, alu_src_a, alu_src_b and alu_op mux encodings
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IF   = 3'd0,
        ST_ID   = 3'd1,
        ST_EX   = 3'd2,
        ST_MEM  = 3'd3,
        ST_WB   = 3'd4,
        ST_HALT = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        CLS_R       = 4'd0,
        CLS_IARITH  = 4'd1,
        CLS_LOAD    = 4'd2,
        CLS_STORE   = 4'd3,
        CLS_BRANCH  = 4'd4,
        CLS_JAL     = 4'd5,
        CLS_JALR    = 4'd6,
        CLS_ECALL   = 4'd7,
        CLS_ILLEGAL = 4'd8
    } inst_class_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IARITH = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // Next-PC mux select
    localparam logic [1:0] PC_SRC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_SRC_ALU    = 2'd2;

    // ALU operand A select
    localparam logic       SRC_A_PC  = 1'b0;
    localparam logic       SRC_A_RS1 = 1'b1;

    // ALU operand B select
    localparam logic [1:0] SRC_B_RS2  = 2'd0;
    localparam logic [1:0] SRC_B_FOUR = 2'd1;
    localparam logic [1:0] SRC_B_IMM  = 2'd2;

    // ALU operation select
    localparam logic [1:0] ALU_OP_ADD    = 2'd0;
    localparam logic [1:0] ALU_OP_BRANCH = 2'd1;
    localparam logic [1:0] ALU_OP_FUNCT  = 2'd2;

endpackage

// File: rtl/multi_cycle_controller_if.sv
// multi_cycle_controller_if
// Bundles the controller's instruction/ALU/memory status inputs and all of
// its datapath control outputs and counters.
//   master : the controller (drives strobes, mux selects and counters)
//   slave  : the datapath/memory side (drives opcode, bcond, halt_cond,
//            mem_ready)
// CNT_W sets the width of cycle_count and retired_count.
interface multi_cycle_controller_if #(
    parameter int CNT_W = 32
);
    logic [6:0]       opcode;
    logic             bcond;
    logic             halt_cond;
    logic             mem_ready;

    logic             pc_write;
    logic [1:0]       pc_source;
    logic             iord;
    logic             mem_read;
    logic             mem_write;
    logic             ir_write;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic             reg_write;
    logic             mem_to_reg;
    logic             pc_to_reg;
    logic             illegal_inst;
    logic             is_halted;
    logic [CNT_W-1:0] cycle_count;
    logic [CNT_W-1:0] retired_count;

    modport master (
        input  opcode, bcond, halt_cond, mem_ready,
        output pc_write, pc_source, iord, mem_read, mem_write, ir_write,
               alu_src_a, alu_src_b, alu_op, reg_write, mem_to_reg,
               pc_to_reg, illegal_inst, is_halted, cycle_count, retired_count
    );

    modport slave (
        output opcode, bcond, halt_cond, mem_ready,
        input  pc_write, pc_source, iord, mem_read, mem_write, ir_write,
               alu_src_a, alu_src_b, alu_op, reg_write, mem_to_reg,
               pc_to_reg, illegal_inst, is_halted, cycle_count, retired_count
    );
endinterface

// File: rtl/mc_opcode_decode.sv
// mc_opcode_decode
// Purely combinational opcode classifier for the multi-cycle controller.
//   opcode     in  7  IR[6:0]
//   inst_class out    instruction class; anything not recognised is ILLEGAL
module mc_opcode_decode
    import mc_ctrl_pkg::*;
(
    input  logic [6:0]  opcode,
    output inst_class_t inst_class
);

    always_comb begin
        inst_class = CLS_ILLEGAL;
        case (opcode)
            OP_R:      inst_class = CLS_R;
            OP_IARITH: inst_class = CLS_IARITH;
            OP_LOAD:   inst_class = CLS_LOAD;
            OP_STORE:  inst_class = CLS_STORE;
            OP_BRANCH: inst_class = CLS_BRANCH;
            OP_JAL:    inst_class = CLS_JAL;
            OP_JALR:   inst_class = CLS_JALR;
            OP_SYSTEM: inst_class = CLS_ECALL;
            default:   inst_class = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multi_cycle_controller.sv
// multi_cycle_controller
// Per-instruction state walk (IF/ID/EX/MEM/WB) for the multi-cycle RV32I
// core, with a sticky HALT state entered by the halting ECALL.
//   clk    in  rising-edge clock
//   reset  in  synchronous, active-low reset
//   bus    master modport of multi_cycle_controller_if:
//          inputs  opcode, bcond, halt_cond, mem_ready
//          outputs PC/IR/regfile/memory strobes, ALU mux selects,
//                  illegal_inst, is_halted, cycle_count, retired_count
module multi_cycle_controller
    import mc_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
)
(
    input  logic                     clk,
    input  logic                     reset,
    multi_cycle_controller_if.master bus
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state;
    state_t           state_next;
    inst_class_t      inst_class;
    logic [CNT_W-1:0] cycle_q;
    logic [CNT_W-1:0] retired_q;

    logic       pc_write_raw;
    logic [1:0] pc_source_raw;
    logic       iord_raw;
    logic       mem_read_raw;
    logic       mem_write_raw;
    logic       ir_write_raw;
    logic       alu_src_a_raw;
    logic [1:0] alu_src_b_raw;
    logic [1:0] alu_op_raw;
    logic       reg_write_raw;
    logic       mem_to_reg_raw;
    logic       pc_to_reg_raw;
    logic       illegal_raw;
    logic       halt_entry;

    mc_opcode_decode u_decode (
        .opcode     (bus.opcode),
        .inst_class (inst_class)
    );

    // State register and counters. The halting ECALL never raises pc_write,
    // so it is retired separately on its transition into HALT.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_IF;
            cycle_q   <= '0;
            retired_q <= '0;
        end else begin
            state   <= state_next;
            cycle_q <= cycle_q + CNT_ONE;
            if (pc_write_raw || halt_entry) begin
                retired_q <= retired_q + CNT_ONE;
            end
        end
    end

    // Next-state and control decode. Everything defaults to 0 so each state
    // only names the controls it actually raises.
    always_comb begin
        state_next     = state;
        pc_write_raw   = 1'b0;
        pc_source_raw  = PC_SRC_PLUS4;
        iord_raw       = 1'b0;
        mem_read_raw   = 1'b0;
        mem_write_raw  = 1'b0;
        ir_write_raw   = 1'b0;
        alu_src_a_raw  = SRC_A_PC;
        alu_src_b_raw  = SRC_B_RS2;
        alu_op_raw     = ALU_OP_ADD;
        reg_write_raw  = 1'b0;
        mem_to_reg_raw = 1'b0;
        pc_to_reg_raw  = 1'b0;
        illegal_raw    = 1'b0;
        halt_entry     = 1'b0;

        case (state)
            ST_IF: begin
                mem_read_raw = 1'b1;
                if (bus.mem_ready) begin
                    ir_write_raw = 1'b1;
                    state_next   = ST_ID;
                end
            end

            // ALUOut <= PC + imm here so branch/JAL targets are ready in EX/WB
            ST_ID: begin
                alu_src_a_raw = SRC_A_PC;
                alu_src_b_raw = SRC_B_IMM;
                alu_op_raw    = ALU_OP_ADD;
                case (inst_class)
                    CLS_ECALL: begin
                        if (bus.halt_cond) begin
                            halt_entry = 1'b1;
                            state_next = ST_HALT;
                        end else begin
                            pc_write_raw = 1'b1;
                            state_next   = ST_IF;
                        end
                    end
                    CLS_ILLEGAL: begin
                        illegal_raw  = 1'b1;
                        pc_write_raw = 1'b1;
                        state_next   = ST_IF;
                    end
                    default: state_next = ST_EX;
                endcase
            end

            ST_EX: begin
                case (inst_class)
                    CLS_R: begin
                        alu_src_a_raw = SRC_A_RS1;
                        alu_src_b_raw = SRC_B_RS2;
                        alu_op_raw    = ALU_OP_FUNCT;
                        state_next    = ST_WB;
                    end
                    CLS_IARITH: begin
                        alu_src_a_raw = SRC_A_RS1;
                        alu_src_b_raw = SRC_B_IMM;
                        alu_op_raw    = ALU_OP_FUNCT;
                        state_next    = ST_WB;
                    end
                    CLS_LOAD, CLS_STORE: begin
                        alu_src_a_raw = SRC_A_RS1;
                        alu_src_b_raw = SRC_B_IMM;
                        alu_op_raw    = ALU_OP_ADD;
                        state_next    = ST_MEM;
                    end
                    CLS_BRANCH: begin
                        alu_src_a_raw = SRC_A_RS1;
                        alu_src_b_raw = SRC_B_RS2;
                        alu_op_raw    = ALU_OP_BRANCH;
                        pc_write_raw  = 1'b1;
                        pc_source_raw = bus.bcond ? PC_SRC_ALUOUT : PC_SRC_PLUS4;
                        state_next    = ST_IF;
                    end
                    CLS_JAL: state_next = ST_WB;
                    CLS_JALR: begin
                        alu_src_a_raw = SRC_A_RS1;
                        alu_src_b_raw = SRC_B_IMM;
                        alu_op_raw    = ALU_OP_ADD;
                        state_next    = ST_WB;
                    end
                    default: state_next = ST_IF;
                endcase
            end

            // The access request stays up unchanged until mem_ready completes it
            ST_MEM: begin
                iord_raw = 1'b1;
                case (inst_class)
                    CLS_LOAD: begin
                        mem_read_raw = 1'b1;
                        if (bus.mem_ready) begin
                            state_next = ST_WB;
                        end
                    end
                    CLS_STORE: begin
                        mem_write_raw = 1'b1;
                        if (bus.mem_ready) begin
                            pc_write_raw = 1'b1;
                            state_next   = ST_IF;
                        end
                    end
                    default: state_next = ST_IF;
                endcase
            end

            // JALR keeps rs1+imm on the ALU so the jump target is the live
            // ALU result while the link address is written back
            ST_WB: begin
                reg_write_raw = 1'b1;
                pc_write_raw  = 1'b1;
                state_next    = ST_IF;
                case (inst_class)
                    CLS_LOAD: mem_to_reg_raw = 1'b1;
                    CLS_JAL: begin
                        pc_to_reg_raw = 1'b1;
                        pc_source_raw = PC_SRC_ALUOUT;
                    end
                    CLS_JALR: begin
                        pc_to_reg_raw = 1'b1;
                        pc_source_raw = PC_SRC_ALU;
                        alu_src_a_raw = SRC_A_RS1;
                        alu_src_b_raw = SRC_B_IMM;
                        alu_op_raw    = ALU_OP_ADD;
                    end
                    default: begin
                        mem_to_reg_raw = 1'b0;
                    end
                endcase
            end

            ST_HALT: state_next = ST_HALT;

            default: state_next = ST_IF;
        endcase
    end

    // Architectural-state strobes are suppressed while reset is held low so
    // nothing is committed before the state register is re-initialised.
    assign bus.pc_write      = reset & pc_write_raw;
    assign bus.ir_write      = reset & ir_write_raw;
    assign bus.reg_write     = reset & reg_write_raw;
    assign bus.mem_read      = reset & mem_read_raw;
    assign bus.mem_write     = reset & mem_write_raw;
    assign bus.pc_source     = pc_source_raw;
    assign bus.iord          = iord_raw;
    assign bus.alu_src_a     = alu_src_a_raw;
    assign bus.alu_src_b     = alu_src_b_raw;
    assign bus.alu_op        = alu_op_raw;
    assign bus.mem_to_reg    = mem_to_reg_raw;
    assign bus.pc_to_reg     = pc_to_reg_raw;
    assign bus.illegal_inst  = illegal_raw;
    assign bus.is_halted     = (state == ST_HALT);
    assign bus.cycle_count   = cycle_q;
    assign bus.retired_count = retired_q;

endmodule

// File: doc/multi_cycle_controller.md
# multi_cycle_controller

Sequencing FSM for the multi-cycle RV32I core. It replaces the single-cycle opcode-to-control lookup with a per-instruction state walk (IF/ID/EX/MEM/WB) that drives PC, IR, ALU-operand, register-file and memory strobes each cycle. It waits on a shared variable-latency memory via a ready handshake, halts on the halt ECALL and keeps retired-instruction and cycle counters. It sits between the instruction register and the datapath muxes and write enables.

## Interface
- CNT_W, 32, width of cycle/retired counters
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- opcode  in  7  IR[6:0], valid from ID onward
- bcond  in  1  branch-taken condition from ALU, sampled in EX of branches
- halt_cond  in  1  ECALL halt request (x17==10), sampled in ID
- mem_ready  in  1  memory completes the current access this cycle
- pc_write  out  1  PC load enable
- pc_source  out  2  0=PC+4, 1=ALUOut (branch/jal target), 2=ALU result (jalr)
- iord  out  1  memory address select: 0=PC, 1=ALUOut
- mem_read, mem_write  out  1 each  memory strobes, held until mem_ready
- ir_write  out  1  IR load enable
- alu_src_a  out  1  0=PC, 1=rs1
- alu_src_b  out  2  0=rs2, 1=4, 2=imm
- alu_op  out  2  0=add, 1=branch compare, 2=funct-decoded
- reg_write, mem_to_reg, pc_to_reg  out  1 each  register writeback controls
- illegal_inst  out  1  one-cycle pulse in ID on unknown opcode
- is_halted  out  1  sticky halt flag
- cycle_count, retired_count  out  CNT_W  free-running counters

## Operation
- States: IF, ID, EX, MEM, WB, HALT. Outputs are Moore-decoded from state plus opcode/bcond/mem_ready; every output not listed for a state is 0.
- IF: mem_read=1, iord=0. Stay while mem_ready=0; on mem_ready=1: ir_write=1, go to ID.
- ID: alu_src_a=0, alu_src_b=2, alu_op=0 (ALUOut<=PC+imm). Opcode 1110011: halt_cond=1 goes to HALT; otherwise pc_write=1, pc_source=0, go to IF. Unknown opcode: illegal_inst=1, pc_write=1, pc_source=0, go to IF (NOP). All other opcodes go to EX.
- EX: R (0110011) uses A=rs1, B=rs2, alu_op=2, then WB. I-arith (0010011) uses A=rs1, B=imm, alu_op=2, then WB. Load/store (0000011/0100011) use A=rs1, B=imm, alu_op=0, then MEM. Branch (1100011) uses A=rs1, B=rs2, alu_op=1, pc_write=1, pc_source=bcond?1:0, then IF. JAL/JALR go straight to WB; JALR drives A=rs1, B=imm, alu_op=0 in EX and holds the same operands in WB.
- MEM: iord=1; mem_read (load) or mem_write (store) stays asserted while mem_ready=0. On mem_ready, a load goes to WB; a store asserts pc_write=1, pc_source=0 and goes to IF.
- WB: reg_write=1 and pc_write=1, then IF. For R/I-arith: mem_to_reg=0, pc_source=0. For load: mem_to_reg=1, pc_source=0. For JAL: pc_to_reg=1, pc_source=1. For JALR: pc_to_reg=1, pc_source=2.
- HALT: absorbing state until reset. is_halted=1, all strobes 0.
- cycle_count increments every non-reset cycle, including in HALT.
- retired_count increments on every cycle with pc_write=1, plus once on entry to HALT (the halting ECALL retires).
- Both counters wrap modulo 2^CNT_W.

## Timing
- Reset: a sampled reset=0 at a rising edge sets state=IF, counters=0 and is_halted=0. While reset=0, pc_write, ir_write, reg_write, mem_read and mem_write are forced to 0. Reset aborts any in-flight memory access and ignores mem_ready.
- Latency with zero-wait memory (mem_ready high):
  - branch/ECALL-continue/illegal: 3 cycles (ECALL and illegal take 2)
  - R, I-arith, JAL, JALR: 4 cycles
  - store: 4 cycles
  - load: 5 cycles
- Each cycle of mem_ready=0 in IF or MEM adds one cycle.
- Handshake: a request is held stable until the cycle mem_ready=1; the transfer completes in that cycle. mem_ready in any other state is ignored.
- illegal_inst pulses in exactly one cycle, the ID cycle.

## Structure
- Package mc_ctrl_pkg holds:
  - the state enum (3-bit: IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=5)
  - opcode constants
  - pc_source, alu_src_b and alu_op encodings
- Sub-module mc_opcode_decode: combinational; maps opcode to a class {R, IARITH, LOAD, STORE, BRANCH, JAL, JALR, ECALL, ILLEGAL}.
- Top holds the state register, next-state logic, output decode and counters.

## Test plan
- ADD, mem_ready tied 1: cycles IF,ID,EX,WB; ir_write at cycle 0; reg_write=1, pc_write=1, pc_source=0 at cycle 3; retired_count 0→1.
- LW with mem_ready low 2 cycles in IF and 3 in MEM: total 10 cycles; mem_read held throughout both waits; iord=1 in MEM; WB has mem_to_reg=1.
- BEQ with bcond=1, then bcond=0: pc_source=1, then 0, with pc_write=1 in EX; no reg_write; 3 cycles each.
- JALR: WB asserts reg_write=1, pc_to_reg=1, pc_source=2.
- Opcode 7'b1111111: illegal_inst=1 for one cycle, PC+4, back to IF. ECALL with halt_cond=1: is_halted=1 sticky, no strobes for 20 cycles, retired_count increments once.
- Reset driven low in MEM mid-store with mem_ready=0: next cycle state=IF, mem_write=0, counters=0. Counter wrap with CNT_W=4: cycle_count 15→0.
